// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage for the single-cycle MIPS datapath.
// Owns the PC and drives it straight to the combinational instruction memory.
// Each returned word is captured with its PC into a 2-entry queue.
// The decoder drains that queue through a valid/ready handshake.
// A redirect loads a new PC and flushes the queue.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   imem_addr [31:0]  byte address to instruction memory (the PC register)
//   imem_data [31:0]  instruction word for imem_addr, combinational
//   redirect_valid    load redirect_pc and flush the queue this cycle
//   redirect_pc[31:0] redirect target; low two bits are forced to zero
//   inst_valid        queue head is valid
//   inst, inst_pc     head instruction word and its PC
//   inst_pc4          inst_pc + 4 (JAL link value)
//   inst_ready        decoder accepts the head when inst_valid is high
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    input  logic        inst_ready
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    entry_t      q [2];
    logic [31:0] pc;
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        push, pop;
    logic [1:0]  unused_redirect_bits;

    // Redirect targets are always word aligned; the low bits carry no meaning.
    assign unused_redirect_bits = redirect_pc[1:0];

    assign imem_addr  = pc;
    assign inst_valid = (count != 2'd0);
    assign inst       = q[rd_ptr].word;
    assign inst_pc    = q[rd_ptr].pc;
    assign inst_pc4   = q[rd_ptr].pc + 32'd4;

    assign pop  = inst_valid && inst_ready;
    // A pop frees the slot the push is about to fill, so a full queue can still
    // accept a word in the same cycle.
    assign push = !redirect_valid && (count != FULL || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) q[i] <= '0;
        end else if (redirect_valid) begin
            // Flush: any pop this cycle is dropped along with the queue.
            pc     <= {redirect_pc[31:2], 2'b00};
            count  <= 2'd0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                q[wr_ptr] <= '{pc: pc, word: imem_data};
                wr_ptr    <= ~wr_ptr;
                pc        <= pc + 32'd4;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst, inst_pc, inst_pc4;
    logic        inst_ready;

    // Wrap-around instance: free-running, always ready, never redirected.
    logic [31:0] w_addr, w_data, w_inst, w_pc, w_pc4;
    logic        w_valid;

    always #5 clk = ~clk;

    // Memory model: each word equals its own address.
    assign imem_data = imem_addr;
    assign w_data    = w_addr;

    fetch_queue dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_pc4(inst_pc4), .inst_ready(inst_ready)
    );

    fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst), .imem_addr(w_addr), .imem_data(w_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .inst_valid(w_valid), .inst(w_inst), .inst_pc(w_pc),
        .inst_pc4(w_pc4), .inst_ready(1'b1)
    );

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rpc;
        logic        ev;     // expected inst_valid
        logic        eh;     // head contents are defined and checked
        logic [31:0] epc;    // expected inst_pc (inst equals it, pc4 = +4)
        logic [31:0] eaddr;  // expected imem_addr
    } vec_t;

    vec_t tv[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic r, logic rdy, logic rv, logic [31:0] rpc,
                                logic ev, logic eh, logic [31:0] epc, logic [31:0] ea);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.eh = eh; v.epc = epc; v.eaddr = ea;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(string tag, logic ev, logic eh, logic [31:0] epc, logic [31:0] ea);
        chk({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, ev});
        chk({tag, ".addr"}, imem_addr, ea);
        if (eh) begin
            chk({tag, ".inst_pc"}, inst_pc, epc);
            chk({tag, ".inst"}, inst, epc);
            chk({tag, ".inst_pc4"}, inst_pc4, epc + 32'd4);
        end
    endtask

    initial begin
        rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        @(negedge clk);
        chk_out("reset", 1'b0, 1'b1, 32'h0, 32'h0);

        //          rst rdy rv rpc        ev eh epc          addr
        // throughput: one per cycle from reset
        tv.push_back(mk(0, 1, 0, 32'h0,   1, 1, 32'h0,   32'h4));
        tv.push_back(mk(0, 1, 0, 32'h0,   1, 1, 32'h4,   32'h8));
        tv.push_back(mk(0, 1, 0, 32'h0,   1, 1, 32'h8,   32'hC));
        tv.push_back(mk(0, 1, 0, 32'h0,   1, 1, 32'hC,   32'h10));
        // reset, then backpressure for 5 cycles
        tv.push_back(mk(1, 0, 0, 32'h0,   0, 1, 32'h0,   32'h0));
        tv.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h0,   32'h4));
        tv.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h0,   32'h8));
        tv.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h0,   32'h8));
        tv.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h0,   32'h8));
        tv.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h0,   32'h8));
        // release: in order, no gaps or duplicates
        tv.push_back(mk(0, 1, 0, 32'h0,   1, 1, 32'h4,   32'hC));
        tv.push_back(mk(0, 1, 0, 32'h0,   1, 1, 32'h8,   32'h10));
        tv.push_back(mk(0, 1, 0, 32'h0,   1, 1, 32'hC,   32'h14));
        tv.push_back(mk(0, 1, 0, 32'h0,   1, 1, 32'h10,  32'h18));
        // stall with a full queue, then redirect to 0x17 with ready high
        tv.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h10,  32'h18));
        tv.push_back(mk(0, 1, 1, 32'h17,  0, 0, 32'h0,   32'h14));
        tv.push_back(mk(0, 1, 0, 32'h0,   1, 1, 32'h14,  32'h18));
        tv.push_back(mk(0, 1, 0, 32'h0,   1, 1, 32'h18,  32'h1C));
        // redirect with one entry queued and ready low, then fill
        tv.push_back(mk(0, 0, 1, 32'h100, 0, 0, 32'h0,   32'h100));
        tv.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h100, 32'h104));
        tv.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h100, 32'h108));
        tv.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h100, 32'h108));
        // full: one-cycle ready pulse pushes and pops together, queue stays full
        tv.push_back(mk(0, 1, 0, 32'h0,   1, 1, 32'h104, 32'h10C));
        tv.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h104, 32'h10C));
        tv.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h104, 32'h10C));

        foreach (tv[i]) begin
            rst = tv[i].rst; inst_ready = tv[i].rdy;
            redirect_valid = tv[i].rv; redirect_pc = tv[i].rpc;
            @(posedge clk);
            @(negedge clk);
            chk_out($sformatf("v%0d", i), tv[i].ev, tv[i].eh, tv[i].epc, tv[i].eaddr);
        end

        // Async reset between edges while the queue is full.
        inst_ready = 1'b0; redirect_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_out("async_rst", 1'b0, 1'b1, 32'h0, 32'h0);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_out("post_rst0", 1'b1, 1'b1, 32'h0, 32'h4);
        inst_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_out("post_rst1", 1'b1, 1'b1, 32'h4, 32'h8);

        // Wrap-around on the second instance.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wrap.rst_addr", w_addr, 32'hFFFF_FFF8);
        chk("wrap.rst_valid", {31'd0, w_valid}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("wrap.pc0", w_pc, 32'hFFFF_FFF8);
        chk("wrap.pc4_0", w_pc4, 32'hFFFF_FFFC);
        chk("wrap.addr0", w_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        @(negedge clk);
        chk("wrap.pc1", w_pc, 32'hFFFF_FFFC);
        chk("wrap.inst1", w_inst, 32'hFFFF_FFFC);
        chk("wrap.pc4_1", w_pc4, 32'h0000_0000);
        chk("wrap.addr1", w_addr, 32'h0000_0000);
        @(posedge clk);
        @(negedge clk);
        chk("wrap.pc2", w_pc, 32'h0000_0000);
        chk("wrap.valid2", {31'd0, w_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
